// File: rtl/fetch_pc_unit.sv
// Program counter and instruction register feeding the multicycle decoder.
// Redirects are latched as a pending target and applied when the decoder retires the instruction.
module fetch_pc_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instrEn,
  input  logic              increment,
  input  logic              displace,
  input  logic              replace,
  input  logic              unconditional,
  input  logic              jal,
  input  logic [ADDR_W-1:0] rtarget,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        bitpattern,
  output logic [3:0]        opcodeex,
  output logic [3:0]        rsrc,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] link,
  output logic              redirect_pending,
  output logic [15:0]       retired
);

  localparam logic [3:0] OP_BCOND = 4'b1100;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [15:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] branch_target;

  assign disp_ext      = ADDR_W'($signed(ir_q[7:0]));
  assign branch_target = pc_q + disp_ext;

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    pend_d    = pend_q;
    target_d  = target_q;
    retired_d = retired_q;
    // Retirement only consults state latched earlier, so it masks any same-cycle strobe.
    if (increment) begin
      pc_d      = pend_q ? target_q : pc_q + ADDR_W'(1);
      pend_d    = 1'b0;
      retired_d = retired_q + 16'd1;
    end else begin
      if (instrEn) begin
        ir_d = imem_rdata;
      end
      if (jal || replace) begin
        target_d = rtarget;
        pend_d   = 1'b1;
      end else if (displace) begin
        target_d = branch_target;
        pend_d   = 1'b1;
      end else if (unconditional) begin
        target_d = (ir_q[15:12] == OP_BCOND) ? branch_target : rtarget;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      pend_q    <= 1'b0;
      target_q  <= '0;
      retired_q <= 16'h0000;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pend_q    <= pend_d;
      target_q  <= target_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr        = pc_q;
  assign instr            = ir_q;
  assign opcode           = ir_q[15:12];
  assign rdest            = ir_q[11:8];
  assign bitpattern       = ir_q[11:8];
  assign opcodeex         = ir_q[7:4];
  assign rsrc             = ir_q[3:0];
  assign imm              = {8'h00, ir_q[7:0]};
  assign link             = pc_q + ADDR_W'(1);
  assign redirect_pending = pend_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized strobes
// compared against a behavioural model of the PC/IR stage.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrEn, increment, displace, replace, unconditional, jal;
  logic [15:0] rtarget;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr, instr, imm, link, retired;
  logic [3:0]  opcode, rdest, bitpattern, opcodeex, rsrc;
  logic        redirect_pending;

  int testsRun = 0;
  int testsFailed = 0;

  int m_pc, m_ir, m_pend, m_tgt, m_retired;

  fetch_pc_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .instrEn(instrEn), .increment(increment),
    .displace(displace), .replace(replace), .unconditional(unconditional),
    .jal(jal), .rtarget(rtarget), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .instr(instr), .opcode(opcode), .rdest(rdest),
    .bitpattern(bitpattern), .opcodeex(opcodeex), .rsrc(rsrc), .imm(imm),
    .link(link), .redirect_pending(redirect_pending), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Behavioural reference: a taken redirect computes its target from the pc of the
  // branch itself; retirement jumps there or falls through to pc+1.
  task automatic modelStep();
    int disp;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_pend = 0; m_tgt = 0; m_retired = 0;
    end else if (increment) begin
      m_pc      = m_pend ? m_tgt : (m_pc + 1) % 65536;
      m_pend    = 0;
      m_retired = (m_retired + 1) % 65536;
    end else begin
      disp = m_ir % 256;
      if (disp >= 128) disp = disp - 256;
      if (jal || replace) begin
        m_tgt = rtarget; m_pend = 1;
      end else if (displace || (unconditional && (m_ir / 4096) == 12)) begin
        m_tgt = (m_pc + disp + 65536) % 65536; m_pend = 1;
      end else if (unconditional) begin
        m_tgt = rtarget; m_pend = 1;
      end
      if (instrEn) m_ir = imem_rdata;
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("instr", instr, m_ir);
    checkOutput("opcode", opcode, m_ir / 4096);
    checkOutput("rdest", rdest, (m_ir / 256) % 16);
    checkOutput("bitpattern", bitpattern, (m_ir / 256) % 16);
    checkOutput("opcodeex", opcodeex, (m_ir / 16) % 16);
    checkOutput("rsrc", rsrc, m_ir % 16);
    checkOutput("imm", imm, m_ir % 256);
    checkOutput("link", link, (m_pc + 1) % 65536);
    checkOutput("redirect_pending", redirect_pending, m_pend);
    checkOutput("retired", retired, m_retired);
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic inc,
                               input logic dsp, input logic rep, input logic unc,
                               input logic jl, input logic [15:0] tgt,
                               input logic [15:0] data);
    @(negedge clk);
    rst = r; instrEn = en; increment = inc; displace = dsp; replace = rep;
    unconditional = unc; jal = jl; rtarget = tgt; imem_rdata = data;
    #1;
    checkOutput("link_in_cycle", link, (m_pc + 1) % 65536);
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic jumpTo(input logic [15:0] addr);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, addr, 16'h0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic loadIr(input logic [15:0] word);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0, word);
  endtask

  task automatic retire();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; instrEn = 0; increment = 0; displace = 0; replace = 0;
    unconditional = 0; jal = 0; rtarget = 16'h0; imem_rdata = 16'h0;
    m_pc = 0; m_ir = 0; m_pend = 0; m_tgt = 0; m_retired = 0;

    applyStimulus(1, 1, 1, 1, 1, 1, 1, 16'hBEEF, 16'hFFFF);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 16'hBEEF, 16'hFFFF);
    checkOutput("reset_pc", imem_addr, 16'h0000);
    checkOutput("reset_instr", instr, 16'h0000);
    checkOutput("reset_retired", retired, 0);
    checkOutput("reset_pending", redirect_pending, 0);
    checkOutput("reset_link", link, 16'h0001);

    loadIr(16'h5103);
    checkOutput("seq_opcode", opcode, 5);
    checkOutput("seq_rdest", rdest, 1);
    checkOutput("seq_imm", imm, 16'h0003);
    retire();
    checkOutput("seq_pc", imem_addr, 16'h0001);
    checkOutput("seq_retired", retired, 1);
    jumpTo(16'hFFFF);
    retire();
    checkOutput("wrap_pc", imem_addr, 16'h0000);

    jumpTo(16'h0010);
    loadIr(16'hC0FE);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
    checkOutput("bcond_pending", redirect_pending, 1);
    retire();
    checkOutput("bcond_disp_pc", imem_addr, 16'h000E);
    jumpTo(16'h0010);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0777, 16'h0);
    retire();
    checkOutput("bcond_unc_pc", imem_addr, 16'h000E);

    loadIr(16'h4EC5);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0200, 16'h0);
    retire();
    checkOutput("jcond_pc", imem_addr, 16'h0200);
    retire();
    checkOutput("jcond_fall_pc", imem_addr, 16'h0201);

    jumpTo(16'h0030);
    loadIr(16'h4A85);
    @(negedge clk);
    jal = 1; rtarget = 16'h0100;
    #1;
    checkOutput("jal_link", link, 16'h0031);
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
    retire();
    checkOutput("jal_pc", imem_addr, 16'h0100);

    jumpTo(16'h0010);
    loadIr(16'hC0F8);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0300, 16'h0);
    retire();
    checkOutput("overwrite_pc", imem_addr, 16'h0300);

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    checkOutput("rst_mid_pc", imem_addr, 16'h0000);
    checkOutput("rst_mid_pending", redirect_pending, 0);
    retire();
    checkOutput("rst_mid_next_pc", imem_addr, 16'h0001);

    applyStimulus(0, 1, 1, 0, 1, 0, 0, 16'h0ABC, 16'h1234);
    checkOutput("inc_beats_instrEn", instr, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 12,
                    $urandom_range(0, 99) < 12,
                    $urandom_range(0, 99) < 12,
                    $urandom_range(0, 99) < 10,
                    16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
